// File: rtl/elelock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : elelock_ctrl
//  Purpose  : Electronic lock controller. Collects a 4-digit code from the
//             debounced keypad stage, checks it against a programmable
//             password and drives the lock / alarm indicators. Handles
//             auto-relock, error hold time, failure counting, lockout and
//             password change while the lock is open.
//  Ports    : ck        in   system clock, rising edge
//             resetn    in   asynchronous active-low reset
//             keycode   in   0-9 digit, A '*' (clear/relock), B '#' (enter),
//                            C-F ignored
//             keyenbl   in   high while a valid key is held
//             locked    out  1 in every state except OPEN
//             unlocked  out  1 in OPEN only
//             alarm     out  1 in ERROR and LOCKOUT
//             digcnt    out  digits currently buffered (0..4)
//             failcnt   out  consecutive failed attempts
//             pwset     out  one-cycle pulse when the password is rewritten
//  Revision : 1.0  initial release
// ============================================================================
module elelock_ctrl #(
  parameter logic [15:0] PASSWORD  = 16'h1234,
  parameter int          OPEN_TIME = 1024,
  parameter int          ERR_TIME  = 64,
  parameter int          MAX_FAIL  = 3
) (
  input  logic       ck,
  input  logic       resetn,
  input  logic [3:0] keycode,
  input  logic       keyenbl,
  output logic       locked,
  output logic       unlocked,
  output logic       alarm,
  output logic [2:0] digcnt,
  output logic [1:0] failcnt,
  output logic       pwset
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPEN    = 2'd1,
    ST_ERROR   = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  localparam logic [15:0] C_OPEN_LOAD = 16'(OPEN_TIME - 1);
  localparam logic [15:0] C_ERR_LOAD  = 16'(ERR_TIME - 1);
  localparam logic [1:0]  C_MAX_FAIL  = 2'(MAX_FAIL);

  state_t      r_state;
  logic        r_ken_d;
  logic        r_armed;
  logic [15:0] r_cbuf;
  logic [15:0] r_pw;
  logic [15:0] r_timer;
  logic        r_tz;     // timer read 0 last cycle: expire now

  state_t      w_state_nxt;
  logic [15:0] w_cbuf_nxt;
  logic [2:0]  w_digcnt_nxt;
  logic [1:0]  w_failcnt_nxt;
  logic [15:0] w_pw_nxt;
  logic [15:0] w_timer_nxt;
  logic        w_tz_nxt;
  logic        w_pwset_nxt;

  logic        w_kev;
  logic        w_is_dig;
  logic        w_is_star;
  logic        w_is_hash;
  logic        w_key_ok;
  logic [2:0]  w_cnt_inc;
  logic [1:0]  w_fail_inc;
  logic        w_code_ok;

  // r_armed stays low for the first cycle after reset so that a key already
  // held at reset release cannot fake a rising edge (r_ken_d catches up first).
  assign w_kev      = keyenbl & ~r_ken_d & r_armed;
  assign w_is_dig   = (keycode <= 4'd9);
  assign w_is_star  = (keycode == 4'hA);
  assign w_is_hash  = (keycode == 4'hB);
  assign w_key_ok   = (keycode <= 4'hB);
  assign w_cnt_inc  = (digcnt >= 3'd4) ? 3'd4 : digcnt + 3'd1;
  assign w_fail_inc = (failcnt >= C_MAX_FAIL) ? C_MAX_FAIL : failcnt + 2'd1;
  assign w_code_ok  = (digcnt == 3'd4) && (r_cbuf == r_pw);

  always_comb begin
    w_state_nxt   = r_state;
    w_cbuf_nxt    = r_cbuf;
    w_digcnt_nxt  = digcnt;
    w_failcnt_nxt = failcnt;
    w_pw_nxt      = r_pw;
    w_tz_nxt      = 1'b0;
    w_pwset_nxt   = 1'b0;
    // Counter holds at 0; the expiry flag carries the extra cycle.
    if ((r_state == ST_OPEN || r_state == ST_ERROR) && r_timer != 16'd0)
      w_timer_nxt = r_timer - 16'd1;
    else
      w_timer_nxt = r_timer;

    case (r_state)
      ST_IDLE: begin
        if (w_kev) begin
          if (w_is_dig) begin
            w_cbuf_nxt   = {r_cbuf[11:0], keycode};
            w_digcnt_nxt = w_cnt_inc;
          end else if (w_is_star) begin
            w_cbuf_nxt   = 16'd0;
            w_digcnt_nxt = 3'd0;
          end else if (w_is_hash) begin
            w_cbuf_nxt   = 16'd0;
            w_digcnt_nxt = 3'd0;
            if (w_code_ok) begin
              w_state_nxt   = ST_OPEN;
              w_failcnt_nxt = 2'd0;
              w_timer_nxt   = C_OPEN_LOAD;
            end else begin
              w_failcnt_nxt = w_fail_inc;
              if (w_fail_inc == C_MAX_FAIL) begin
                w_state_nxt = ST_LOCKOUT;
              end else begin
                w_state_nxt = ST_ERROR;
                w_timer_nxt = C_ERR_LOAD;
              end
            end
          end
        end
      end

      ST_OPEN: begin
        if (r_tz) begin
          // Expiry takes priority over any coincident key.
          w_state_nxt  = ST_IDLE;
          w_cbuf_nxt   = 16'd0;
          w_digcnt_nxt = 3'd0;
        end else begin
          w_tz_nxt = (r_timer == 16'd0);
          if (w_kev && w_key_ok) begin
            w_timer_nxt = C_OPEN_LOAD;
            w_tz_nxt    = 1'b0;
            if (w_is_dig) begin
              w_cbuf_nxt   = {r_cbuf[11:0], keycode};
              w_digcnt_nxt = w_cnt_inc;
            end else if (w_is_hash) begin
              if (digcnt == 3'd4) begin
                w_pw_nxt    = r_cbuf;
                w_pwset_nxt = 1'b1;
              end
              w_cbuf_nxt   = 16'd0;
              w_digcnt_nxt = 3'd0;
            end else begin
              w_state_nxt  = ST_IDLE;
              w_cbuf_nxt   = 16'd0;
              w_digcnt_nxt = 3'd0;
            end
          end
        end
      end

      ST_ERROR: begin
        if (r_tz)
          w_state_nxt = ST_IDLE;
        else
          w_tz_nxt = (r_timer == 16'd0);
      end

      default: begin
        // LOCKOUT: held until reset.
        w_state_nxt = ST_LOCKOUT;
      end
    endcase
  end

  always_ff @(posedge ck or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_ken_d  <= 1'b0;
      r_armed  <= 1'b0;
      r_cbuf   <= 16'd0;
      r_pw     <= PASSWORD;
      r_timer  <= 16'd0;
      r_tz     <= 1'b0;
      locked   <= 1'b1;
      unlocked <= 1'b0;
      alarm    <= 1'b0;
      digcnt   <= 3'd0;
      failcnt  <= 2'd0;
      pwset    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ken_d  <= keyenbl;
      r_armed  <= 1'b1;
      r_cbuf   <= w_cbuf_nxt;
      r_pw     <= w_pw_nxt;
      r_timer  <= w_timer_nxt;
      r_tz     <= w_tz_nxt;
      locked   <= (w_state_nxt != ST_OPEN);
      unlocked <= (w_state_nxt == ST_OPEN);
      alarm    <= (w_state_nxt == ST_ERROR) || (w_state_nxt == ST_LOCKOUT);
      digcnt   <= w_digcnt_nxt;
      failcnt  <= w_failcnt_nxt;
      pwset    <= w_pwset_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_elelock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_elelock_ctrl
//  Purpose  : Directed self-checking bench for elelock_ctrl with short
//             timers (OPEN_TIME=8, ERR_TIME=4, MAX_FAIL=3).
//  Revision : 1.0  initial release
// ============================================================================
module tb_elelock_ctrl;

  logic       ck;
  logic       resetn;
  logic [3:0] keycode;
  logic       keyenbl;
  logic       locked;
  logic       unlocked;
  logic       alarm;
  logic [2:0] digcnt;
  logic [1:0] failcnt;
  logic       pwset;

  int n_cmp;
  int n_err;

  elelock_ctrl #(
    .PASSWORD (16'h1234),
    .OPEN_TIME(8),
    .ERR_TIME (4),
    .MAX_FAIL (3)
  ) dut (
    .ck      (ck),
    .resetn  (resetn),
    .keycode (keycode),
    .keyenbl (keyenbl),
    .locked  (locked),
    .unlocked(unlocked),
    .alarm   (alarm),
    .digcnt  (digcnt),
    .failcnt (failcnt),
    .pwset   (pwset)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge ck);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 3-cycle keyenbl pulse followed by one idle cycle.
  task automatic press(input logic [3:0] k);
    keycode = k;
    keyenbl = 1'b1;
    tick(3);
    keyenbl = 1'b0;
    tick(1);
  endtask

  task automatic enter4(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
    press(a);
    press(b);
    press(c);
    press(d);
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    resetn  = 1'b0;
    keycode = 4'h0;
    keyenbl = 1'b0;
    tick(2);

    // Reset state
    chk("rst_locked",   16'(locked),   16'd1);
    chk("rst_unlocked", 16'(unlocked), 16'd0);
    chk("rst_alarm",    16'(alarm),    16'd0);
    chk("rst_digcnt",   16'(digcnt),   16'd0);
    chk("rst_failcnt",  16'(failcnt),  16'd0);
    chk("rst_pwset",    16'(pwset),    16'd0);
    resetn = 1'b1;
    tick(2);

    // Correct code, then auto-relock after OPEN_TIME+1 cycles
    enter4(4'h1, 4'h2, 4'h3, 4'h4);
    chk("fill_digcnt", 16'(digcnt), 16'd4);
    keycode = 4'hB;
    keyenbl = 1'b1;
    tick(1);
    chk("open_unlocked", 16'(unlocked), 16'd1);
    chk("open_locked",   16'(locked),   16'd0);
    chk("open_digcnt",   16'(digcnt),   16'd0);
    tick(2);
    keyenbl = 1'b0;
    tick(6);
    chk("open_last_cycle", 16'(unlocked), 16'd1);
    tick(1);
    chk("relock_locked",   16'(locked),   16'd1);
    chk("relock_unlocked", 16'(unlocked), 16'd0);

    // Wrong code: alarm for ERR_TIME+1 cycles, then a correct entry
    enter4(4'h1, 4'h2, 4'h3, 4'h5);
    keycode = 4'hB;
    keyenbl = 1'b1;
    tick(1);
    chk("err_alarm",   16'(alarm),   16'd1);
    chk("err_failcnt", 16'(failcnt), 16'd1);
    chk("err_digcnt",  16'(digcnt),  16'd0);
    tick(2);
    keyenbl = 1'b0;
    tick(2);
    chk("err_last_cycle", 16'(alarm), 16'd1);
    tick(1);
    chk("err_done_alarm",  16'(alarm),  16'd0);
    chk("err_done_locked", 16'(locked), 16'd1);
    enter4(4'h1, 4'h2, 4'h3, 4'h4);
    press(4'hB);
    chk("reopen_unlocked", 16'(unlocked), 16'd1);
    chk("reopen_failcnt",  16'(failcnt),  16'd0);
    press(4'hA);
    chk("star_relock", 16'(locked), 16'd1);

    // Three failures -> lockout; correct code ignored; reset recovers
    enter4(4'h1, 4'h1, 4'h1, 4'h1);
    press(4'hB);
    chk("fail1_cnt", 16'(failcnt), 16'd1);
    tick(4);
    enter4(4'h1, 4'h1, 4'h1, 4'h1);
    press(4'hB);
    chk("fail2_cnt", 16'(failcnt), 16'd2);
    tick(4);
    enter4(4'h1, 4'h1, 4'h1, 4'h1);
    press(4'hB);
    chk("lock_failcnt", 16'(failcnt), 16'd3);
    chk("lock_alarm",   16'(alarm),   16'd1);
    enter4(4'h1, 4'h2, 4'h3, 4'h4);
    press(4'hB);
    tick(20);
    chk("lock_hold_alarm",  16'(alarm),  16'd1);
    chk("lock_hold_locked", 16'(locked), 16'd1);
    chk("lock_hold_digcnt", 16'(digcnt), 16'd0);
    resetn = 1'b0;
    tick(1);
    chk("lock_rst_alarm",   16'(alarm),   16'd0);
    chk("lock_rst_failcnt", 16'(failcnt), 16'd0);
    resetn = 1'b1;
    tick(2);

    // Password change while open
    enter4(4'h1, 4'h2, 4'h3, 4'h4);
    press(4'hB);
    chk("pw_open", 16'(unlocked), 16'd1);
    enter4(4'h9, 4'h8, 4'h7, 4'h6);
    keycode = 4'hB;
    keyenbl = 1'b1;
    tick(1);
    chk("pwset_pulse", 16'(pwset),    16'd1);
    chk("pwset_open",  16'(unlocked), 16'd1);
    tick(1);
    chk("pwset_end", 16'(pwset), 16'd0);
    tick(1);
    keyenbl = 1'b0;
    tick(1);
    press(4'hA);
    chk("pw_star_idle", 16'(locked), 16'd1);
    enter4(4'h9, 4'h8, 4'h7, 4'h6);
    press(4'hB);
    chk("newpw_open", 16'(unlocked), 16'd1);
    press(4'hA);
    enter4(4'h1, 4'h2, 4'h3, 4'h4);
    press(4'hB);
    chk("oldpw_alarm",   16'(alarm),   16'd1);
    chk("oldpw_failcnt", 16'(failcnt), 16'd1);
    tick(4);
    // Reset restores the default password
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    tick(2);
    enter4(4'h1, 4'h2, 4'h3, 4'h4);
    press(4'hB);
    chk("pw_revert_open", 16'(unlocked), 16'd1);
    press(4'hA);

    // Five digits: oldest dropped, digcnt saturates
    press(4'h5);
    enter4(4'h1, 4'h2, 4'h3, 4'h4);
    chk("sat_digcnt", 16'(digcnt), 16'd4);
    press(4'hB);
    chk("sat_open", 16'(unlocked), 16'd1);
    press(4'hA);
    press(4'h1);
    press(4'h2);
    chk("short_digcnt", 16'(digcnt), 16'd2);
    press(4'hB);
    chk("short_alarm",   16'(alarm),   16'd1);
    chk("short_failcnt", 16'(failcnt), 16'd1);
    tick(4);
    chk("short_back_idle", 16'(alarm), 16'd0);

    // Held key gives one event; ignored codes change nothing
    keycode = 4'h1;
    keyenbl = 1'b1;
    tick(20);
    chk("hold_digcnt", 16'(digcnt), 16'd1);
    keyenbl = 1'b0;
    tick(1);
    press(4'hA);
    chk("star_clear", 16'(digcnt), 16'd0);
    press(4'hC);
    press(4'hC);
    press(4'hF);
    chk("ign_digcnt",   16'(digcnt),   16'd0);
    chk("ign_locked",   16'(locked),   16'd1);
    chk("ign_unlocked", 16'(unlocked), 16'd0);
    chk("ign_alarm",    16'(alarm),    16'd0);
    chk("ign_failcnt",  16'(failcnt),  16'd1);
    chk("ign_pwset",    16'(pwset),    16'd0);

    // Key already held at reset release: no event until re-pressed
    keycode = 4'h7;
    keyenbl = 1'b1;
    resetn  = 1'b0;
    tick(1);
    resetn = 1'b1;
    tick(4);
    chk("held_rst_digcnt", 16'(digcnt), 16'd0);
    keyenbl = 1'b0;
    tick(1);
    press(4'h7);
    chk("held_rst_repress", 16'(digcnt), 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
